// File: rtl/flash_prog_pkg.sv
// Shared encodings for the flash program/erase sequencer.
package flash_prog_pkg;

  typedef enum logic [1:0] {
    OP_NONE         = 2'd0,
    OP_PROGRAM      = 2'd1,
    OP_SECTOR_ERASE = 2'd2,
    OP_CHIP_ERASE   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BW,
    ST_POLL_OE,
    ST_POLL_CHK
  } state_t;

  // Phase within one three-cycle flash bus write
  typedef enum logic [1:0] {
    BW_S0,
    BW_S1,
    BW_S2
  } bw_phase_t;

  // Address source for one step of a write sequence
  typedef enum logic [1:0] {
    ASEL_A1,
    ASEL_A2,
    ASEL_TARGET,
    ASEL_SECTOR
  } addr_sel_t;

  localparam logic [7:0] JEDEC_AA = 8'hAA;
  localparam logic [7:0] JEDEC_55 = 8'h55;
  localparam logic [7:0] JEDEC_A0 = 8'hA0;
  localparam logic [7:0] JEDEC_80 = 8'h80;
  localparam logic [7:0] JEDEC_30 = 8'h30;
  localparam logic [7:0] JEDEC_10 = 8'h10;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_CMD     = 2'd3;

  function automatic logic [7:0] status_byte(input logic tmo, input logic done,
                                             input logic busy);
    return {5'b0, tmo, done, busy};
  endfunction

endpackage

// File: rtl/flash_seq_rom.sv
// JEDEC command sequence table: (op, step) -> address source, data byte, last.
// For ASEL_TARGET steps the byte comes from the DATA register, not this table.
module flash_seq_rom
  import flash_prog_pkg::*;
(
  input  logic [1:0] op,
  input  logic [2:0] step,
  output logic [1:0] addr_sel,
  output logic [7:0] data,
  output logic       last
);

  // Sequence lookup; unused (op, step) pairs end the sequence defensively
  always_comb begin
    addr_sel = ASEL_A1;
    data     = '0;
    last     = 1'b1;
    case (op)
      OP_PROGRAM: begin
        case (step)
          3'd0: begin addr_sel = ASEL_A1;     data = JEDEC_AA; last = 1'b0; end
          3'd1: begin addr_sel = ASEL_A2;     data = JEDEC_55; last = 1'b0; end
          3'd2: begin addr_sel = ASEL_A1;     data = JEDEC_A0; last = 1'b0; end
          3'd3: begin addr_sel = ASEL_TARGET; data = '0;       last = 1'b1; end
          default: ;
        endcase
      end
      OP_SECTOR_ERASE, OP_CHIP_ERASE: begin
        case (step)
          3'd0: begin addr_sel = ASEL_A1; data = JEDEC_AA; last = 1'b0; end
          3'd1: begin addr_sel = ASEL_A2; data = JEDEC_55; last = 1'b0; end
          3'd2: begin addr_sel = ASEL_A1; data = JEDEC_80; last = 1'b0; end
          3'd3: begin addr_sel = ASEL_A1; data = JEDEC_AA; last = 1'b0; end
          3'd4: begin addr_sel = ASEL_A2; data = JEDEC_55; last = 1'b0; end
          3'd5: begin
            if (op == OP_SECTOR_ERASE) begin
              addr_sel = ASEL_SECTOR;
              data     = JEDEC_30;
            end else begin
              addr_sel = ASEL_A1;
              data     = JEDEC_10;
            end
            last = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/flash_prog_seq.sv
// In-circuit program/erase sequencer for the 128K x 8 ROM flash.
// Idle: CPU ROM accesses pass straight through. Busy: owns the flash bus,
// issues the JEDEC write sequence, then polls DQ7 until done or timeout.
module flash_prog_seq
  import flash_prog_pkg::*;
#(
  parameter logic [19:0] POLL_TIMEOUT = 20'd200000,
  parameter logic [16:0] UNLOCK_A1    = 17'h05555,
  parameter logic [16:0] UNLOCK_A2    = 17'h02AAA
) (
  input  logic        PHI2,
  input  logic        Reset,
  input  logic        RegWr,
  input  logic        RegRd,
  input  logic [1:0]  RegSel,
  input  logic [7:0]  DIn,
  output logic [7:0]  DOut,
  input  logic        CpuRomCS,
  input  logic [16:0] CpuRA,
  input  logic        CpuRDS,
  output logic [16:0] FlashA,
  output logic [7:0]  FlashDOut,
  output logic        FlashDOE,
  input  logic [7:0]  FlashDIn,
  output logic        NFlashCE,
  output logic        NFlashOE,
  output logic        NFlashWE,
  output logic        CpuRdy,
  output logic        Busy
);

  logic [7:0]  data_reg;
  logic [7:0]  addr_lo;
  logic [7:0]  addr_hi;
  logic [2:0]  cmd_reg;
  logic        done;
  logic        tmo_flag;
  state_t      state;
  bw_phase_t   phase;
  logic [2:0]  step;
  logic [19:0] poll_cnt;
  logic        poll_bit;

  state_t      state_n;
  bw_phase_t   phase_n;
  logic [2:0]  step_n;
  logic [19:0] poll_cnt_n;
  logic        done_n;
  logic        tmo_n;

  logic        busy;
  logic        reg_wr_ok;
  logic        cmd_wr;
  op_t         op;
  logic [16:0] target;
  logic [16:0] sector;
  logic [16:0] poll_addr;
  logic        poll_expect;
  logic [1:0]  rom_addr_sel;
  logic [7:0]  rom_data;
  logic        rom_last;
  logic [16:0] seq_addr;
  logic [7:0]  seq_data;

  // DQ6..DQ0 carry no information for DQ7 polling
  logic unused_din;
  assign unused_din = ^FlashDIn[6:0];

  assign busy      = (state != ST_IDLE);
  assign Busy      = busy;
  assign reg_wr_ok = RegWr & ~busy;
  assign cmd_wr    = reg_wr_ok & (RegSel == REG_CMD);
  assign op        = op_t'(cmd_reg[1:0]);
  assign target    = {cmd_reg[2], addr_hi, addr_lo};
  assign sector    = {target[16:12], 12'h000};

  flash_seq_rom u_rom (
    .op       (cmd_reg[1:0]),
    .step     (step),
    .addr_sel (rom_addr_sel),
    .data     (rom_data),
    .last     (rom_last)
  );

  // Resolve the table's address source and data byte for the current step
  always_comb begin
    seq_addr = UNLOCK_A1;
    seq_data = rom_data;
    case (addr_sel_t'(rom_addr_sel))
      ASEL_A1:     seq_addr = UNLOCK_A1;
      ASEL_A2:     seq_addr = UNLOCK_A2;
      ASEL_TARGET: begin
        seq_addr = target;
        seq_data = data_reg;
      end
      ASEL_SECTOR: seq_addr = sector;
      default:     seq_addr = UNLOCK_A1;
    endcase
  end

  // Poll address and expected DQ7 value depend on the operation in flight
  always_comb begin
    poll_addr   = UNLOCK_A1;
    poll_expect = 1'b1;
    case (op)
      OP_PROGRAM: begin
        poll_addr   = target;
        poll_expect = data_reg[7];
      end
      OP_SECTOR_ERASE: poll_addr = sector;
      default:         poll_addr = UNLOCK_A1;
    endcase
  end

  // CPU-visible registers; writes are ignored while the sequencer is busy
  always_ff @(posedge PHI2 or posedge Reset) begin
    if (Reset) begin
      data_reg <= '0;
      addr_lo  <= '0;
      addr_hi  <= '0;
      cmd_reg  <= '0;
    end else if (reg_wr_ok) begin
      case (RegSel)
        REG_DATA:    data_reg <= DIn;
        REG_ADDR_LO: addr_lo  <= DIn;
        REG_ADDR_HI: addr_hi  <= DIn;
        default:     cmd_reg  <= DIn[2:0];
      endcase
    end
  end

  // Sequencer state register; DQ7 is captured at the end of the OE cycle
  always_ff @(posedge PHI2 or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      phase    <= BW_S0;
      step     <= '0;
      poll_cnt <= '0;
      done     <= 1'b0;
      tmo_flag <= 1'b0;
      poll_bit <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      step     <= step_n;
      poll_cnt <= poll_cnt_n;
      done     <= done_n;
      tmo_flag <= tmo_n;
      if (state == ST_POLL_OE) poll_bit <= FlashDIn[7];
    end
  end

  // Next-state logic: write sequence, then DQ7 poll loop with timeout
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    step_n     = step;
    poll_cnt_n = poll_cnt;
    done_n     = done;
    tmo_n      = tmo_flag;
    case (state)
      ST_IDLE: begin
        if (cmd_wr) begin
          done_n = 1'b0;
          tmo_n  = 1'b0;
          if (DIn[1:0] != OP_NONE) state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        step_n     = '0;
        phase_n    = BW_S0;
        poll_cnt_n = '0;
        state_n    = ST_BW;
      end
      ST_BW: begin
        case (phase)
          BW_S0: phase_n = BW_S1;
          BW_S1: phase_n = BW_S2;
          default: begin
            phase_n = BW_S0;
            if (rom_last) state_n = ST_POLL_OE;
            else          step_n  = step + 3'd1;
          end
        endcase
      end
      ST_POLL_OE: state_n = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (poll_bit == poll_expect) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else if ((poll_cnt + 20'd1) >= POLL_TIMEOUT) begin
          done_n  = 1'b1;
          tmo_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          poll_cnt_n = poll_cnt + 20'd1;
          state_n    = ST_POLL_OE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Flash pin and CPU handshake outputs; pass-through whenever idle
  always_comb begin
    FlashA    = CpuRA;
    FlashDOut = '0;
    FlashDOE  = 1'b0;
    NFlashCE  = ~CpuRomCS;
    NFlashOE  = ~(CpuRomCS & CpuRDS);
    NFlashWE  = 1'b1;
    CpuRdy    = 1'b1;
    if (busy) begin
      CpuRdy   = ~CpuRomCS;
      FlashA   = seq_addr;
      NFlashCE = 1'b1;
      NFlashOE = 1'b1;
      case (state)
        ST_BW: begin
          NFlashCE  = 1'b0;
          FlashDOE  = 1'b1;
          FlashDOut = seq_data;
          NFlashWE  = (phase != BW_S1);
        end
        ST_POLL_OE: begin
          FlashA   = poll_addr;
          NFlashCE = 1'b0;
          NFlashOE = 1'b0;
        end
        ST_POLL_CHK: begin
          FlashA   = poll_addr;
          NFlashCE = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Register read port
  always_comb begin
    DOut = '0;
    if (RegRd) begin
      case (RegSel)
        REG_DATA:    DOut = data_reg;
        REG_ADDR_LO: DOut = addr_lo;
        REG_ADDR_HI: DOut = addr_hi;
        default:     DOut = status_byte(tmo_flag, done, busy);
      endcase
    end
  end

endmodule

// File: tb/tb_flash_prog_seq.sv
// Bench for flash_prog_seq: register/pass-through tables, plus scoreboarded
// program, erase, timeout and reset-abort sequences against a DQ7 flash model.
module tb_flash_prog_seq;
  import flash_prog_pkg::*;

  logic        PHI2 = 1'b0;
  logic        Reset;
  logic        RegWr;
  logic        RegRd;
  logic [1:0]  RegSel;
  logic [7:0]  DIn;
  logic [7:0]  DOut;
  logic        CpuRomCS;
  logic [16:0] CpuRA;
  logic        CpuRDS;
  logic [16:0] FlashA;
  logic [7:0]  FlashDOut;
  logic        FlashDOE;
  logic [7:0]  FlashDIn;
  logic        NFlashCE;
  logic        NFlashOE;
  logic        NFlashWE;
  logic        CpuRdy;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  // Flash model: DQ7 reads the complement of the final value until
  // poll_target polls have been seen
  int   polls_seen  = 0;
  int   poll_target = 0;
  logic poll_good   = 1'b0;
  assign FlashDIn = {(polls_seen > poll_target) ? poll_good : ~poll_good, 7'h00};

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } bw_t;
  bw_t sb[$];

  typedef struct {
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } reg_vec_t;

  typedef struct {
    logic        cs;
    logic        rds;
    logic [16:0] ra;
    logic [16:0] exp_a;
    logic        exp_nce;
    logic        exp_noe;
    logic        exp_rdy;
  } pt_vec_t;

  always #5 PHI2 = ~PHI2;

  flash_prog_seq #(
    .POLL_TIMEOUT (20'd100)
  ) dut (
    .PHI2      (PHI2),
    .Reset     (Reset),
    .RegWr     (RegWr),
    .RegRd     (RegRd),
    .RegSel    (RegSel),
    .DIn       (DIn),
    .DOut      (DOut),
    .CpuRomCS  (CpuRomCS),
    .CpuRA     (CpuRA),
    .CpuRDS    (CpuRDS),
    .FlashA    (FlashA),
    .FlashDOut (FlashDOut),
    .FlashDOE  (FlashDOE),
    .FlashDIn  (FlashDIn),
    .NFlashCE  (NFlashCE),
    .NFlashOE  (NFlashOE),
    .NFlashWE  (NFlashWE),
    .CpuRdy    (CpuRdy),
    .Busy      (Busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
    @(posedge PHI2); #1;
    RegWr  = 1'b1;
    RegSel = sel;
    DIn    = d;
    @(posedge PHI2); #1;
    RegWr  = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [7:0] d);
    RegRd  = 1'b1;
    RegSel = sel;
    #1;
    d      = DOut;
    RegRd  = 1'b0;
  endtask

  task automatic push_bw(input logic [16:0] a, input logic [7:0] d);
    bw_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_unlock3(input logic [7:0] third);
    push_bw(17'h05555, 8'hAA);
    push_bw(17'h02AAA, 8'h55);
    push_bw(17'h05555, third);
  endtask

  // Steps the DUT one cycle at a time from just after a CMD write, popping the
  // scoreboard on each WE pulse and counting DQ7 polls.
  task automatic run_op(input string tag, input int exp_writes, input int poll_n,
                        input logic exp_bit, input logic [16:0] exp_pa,
                        input int exp_polls, input logic [7:0] exp_status,
                        input bit hammer, input bit drop, input int reset_at);
    int   cyc = 0;
    int   we_low = 0;
    int   nwrites = 0;
    int   rdy_bad = 0;
    int   oe_bad = 0;
    int   width_bad = 0;
    int   pa_bad = 0;
    int   strobe_bad = 0;
    bit   aborted = 0;
    bit   idle_seen = 0;
    logic [7:0] st;
    bw_t  e;
    polls_seen  = 0;
    poll_target = poll_n;
    poll_good   = exp_bit;
    CpuRomCS    = hammer;
    CpuRDS      = hammer;
    CpuRA       = 17'h0C000;
    while (cyc < 2000 && !idle_seen && !aborted) begin
      @(negedge PHI2);
      cyc++;
      RegWr = 1'b0;
      if (!Busy) begin
        idle_seen = 1;
      end else begin
        if (CpuRdy !== ~CpuRomCS) rdy_bad++;
        if (!NFlashWE) begin
          we_low++;
          if (we_low == 1) begin
            nwrites++;
            if (NFlashCE || !FlashDOE) strobe_bad++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL %s_write: unexpected write %0h<-%0h", tag, FlashA, FlashDOut);
            end else begin
              e = sb.pop_front();
              check({tag, "_wr_addr"}, 32'(FlashA), 32'(e.a));
              check({tag, "_wr_data"}, 32'(FlashDOut), 32'(e.d));
            end
            if (nwrites == reset_at) begin
              Reset = 1'b1;
              #1;
              check({tag, "_rst_we"}, 32'(NFlashWE), 32'd1);
              check({tag, "_rst_busy"}, 32'(Busy), 32'd0);
              sb.delete();
              aborted = 1;
            end
          end
        end else begin
          if (we_low > 1) width_bad++;
          we_low = 0;
        end
        if (!aborted && !NFlashOE) begin
          if (nwrites < exp_writes) oe_bad++;
          else begin
            polls_seen++;
            if (FlashA !== exp_pa) pa_bad++;
          end
        end
        if (drop && cyc == 5) begin
          RegWr = 1'b1; RegSel = REG_DATA; DIn = 8'hFF;
        end
        if (drop && cyc == 9) begin
          RegWr = 1'b1; RegSel = REG_CMD; DIn = 8'h03;
        end
      end
    end
    RegWr    = 1'b0;
    CpuRomCS = 1'b0;
    CpuRDS   = 1'b0;
    if (aborted) begin
      @(posedge PHI2); #1;
      Reset = 1'b0;
    end else if (!idle_seen) begin
      checks++;
      errors++;
      $display("FAIL %s_busy: still busy after %0d cycles, expected idle", tag, cyc);
    end else begin
      // Same cycle that Busy fell
      reg_read(REG_CMD, st);
      check({tag, "_status"}, 32'(st), 32'(exp_status));
      check({tag, "_cycles"}, cyc, 2 + 3 * exp_writes + 2 * exp_polls);
      check({tag, "_nwrites"}, nwrites, exp_writes);
      check({tag, "_polls"}, polls_seen, exp_polls);
      check({tag, "_sb_left"}, sb.size(), 0);
      check({tag, "_we_width"}, width_bad, 0);
      check({tag, "_we_strobe"}, strobe_bad, 0);
      check({tag, "_rdy"}, rdy_bad, 0);
      check({tag, "_cpu_oe"}, oe_bad, 0);
      check({tag, "_poll_addr"}, pa_bad, 0);
    end
  endtask

  initial begin
    reg_vec_t   regs[3];
    pt_vec_t    pt[4];
    logic [7:0] rd;

    Reset = 1'b1; RegWr = 1'b0; RegRd = 1'b0; RegSel = '0; DIn = '0;
    CpuRomCS = 1'b0; CpuRA = '0; CpuRDS = 1'b0;

    regs[0] = '{REG_DATA,    8'h5A, 8'h5A};
    regs[1] = '{REG_ADDR_LO, 8'h45, 8'h45};
    regs[2] = '{REG_ADDR_HI, 8'h23, 8'h23};

    pt[0] = '{1'b1, 1'b1, 17'h0C000, 17'h0C000, 1'b0, 1'b0, 1'b1};
    pt[1] = '{1'b1, 1'b0, 17'h1FFFF, 17'h1FFFF, 1'b0, 1'b1, 1'b1};
    pt[2] = '{1'b0, 1'b1, 17'h00123, 17'h00123, 1'b1, 1'b1, 1'b1};
    pt[3] = '{1'b0, 1'b0, 17'h15555, 17'h15555, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge PHI2);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_we", 32'(NFlashWE), 32'd1);
    check("rst_doe", 32'(FlashDOE), 32'd0);
    Reset = 1'b0;
    @(posedge PHI2); #1;
    reg_read(REG_CMD, rd);
    check("rst_status", 32'(rd), 32'h00);
    reg_read(REG_DATA, rd);
    check("rst_data", 32'(rd), 32'h00);
    check("dout_no_rd", 32'(DOut), 32'h00);

    // Register write/readback table
    for (int i = 0; i < 3; i++) reg_write(regs[i].sel, regs[i].wdata);
    for (int i = 0; i < 3; i++) begin
      reg_read(regs[i].sel, rd);
      check($sformatf("reg_rd%0d", i), 32'(rd), 32'(regs[i].rdata));
    end

    // PROGRAM 12345 <- 5A, CPU hammering ROM throughout (must stall)
    push_unlock3(8'hA0);
    push_bw(17'h12345, 8'h5A);
    reg_write(REG_CMD, 8'h05);
    run_op("prog", 4, 10, 1'b0, 17'h12345, 11, 8'h02, 1'b1, 1'b0, 0);

    // Pass-through table after Done
    for (int i = 0; i < 4; i++) begin
      CpuRomCS = pt[i].cs;
      CpuRDS   = pt[i].rds;
      CpuRA    = pt[i].ra;
      #1;
      check($sformatf("pt%0d_a", i), 32'(FlashA), 32'(pt[i].exp_a));
      check($sformatf("pt%0d_nce", i), 32'(NFlashCE), 32'(pt[i].exp_nce));
      check($sformatf("pt%0d_noe", i), 32'(NFlashOE), 32'(pt[i].exp_noe));
      check($sformatf("pt%0d_rdy", i), 32'(CpuRdy), 32'(pt[i].exp_rdy));
      check($sformatf("pt%0d_we", i), 32'(NFlashWE), 32'd1);
      check($sformatf("pt%0d_doe", i), 32'(FlashDOE), 32'd0);
    end
    CpuRomCS = 1'b0; CpuRDS = 1'b0;

    // SECTOR_ERASE at 0A7xx, RAM cycles only, DATA/CMD writes while busy dropped
    reg_write(REG_ADDR_HI, 8'hA7);
    push_unlock3(8'h80);
    push_bw(17'h05555, 8'hAA);
    push_bw(17'h02AAA, 8'h55);
    push_bw(17'h0A000, 8'h30);
    reg_write(REG_CMD, 8'h02);
    run_op("serase", 6, 50, 1'b1, 17'h0A000, 51, 8'h02, 1'b0, 1'b1, 0);
    reg_read(REG_DATA, rd);
    check("drop_data", 32'(rd), 32'h5A);
    reg_write(REG_CMD, 8'h00);
    reg_read(REG_CMD, rd);
    check("clr_status", 32'(rd), 32'h00);

    // CHIP_ERASE, completes on first poll at A1
    push_unlock3(8'h80);
    push_bw(17'h05555, 8'hAA);
    push_bw(17'h02AAA, 8'h55);
    push_bw(17'h05555, 8'h10);
    reg_write(REG_CMD, 8'h03);
    run_op("cerase", 6, 0, 1'b1, 17'h05555, 1, 8'h02, 1'b0, 1'b0, 0);

    // Timeout: flash never completes
    reg_write(REG_ADDR_HI, 8'h23);
    push_unlock3(8'hA0);
    push_bw(17'h12345, 8'h5A);
    reg_write(REG_CMD, 8'h05);
    run_op("tmo", 4, 1000000, 1'b0, 17'h12345, 100, 8'h06, 1'b0, 1'b0, 0);

    // Reset during S1 of the third write
    push_unlock3(8'hA0);
    push_bw(17'h12345, 8'h5A);
    reg_write(REG_CMD, 8'h05);
    run_op("rstmid", 4, 0, 1'b0, 17'h12345, 1, 8'h02, 1'b0, 1'b0, 3);
    reg_read(REG_DATA, rd);
    check("rstmid_data", 32'(rd), 32'h00);
    reg_read(REG_ADDR_LO, rd);
    check("rstmid_alo", 32'(rd), 32'h00);
    reg_read(REG_ADDR_HI, rd);
    check("rstmid_ahi", 32'(rd), 32'h00);
    reg_read(REG_CMD, rd);
    check("rstmid_status", 32'(rd), 32'h00);
    check("rstmid_we", 32'(NFlashWE), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
